// File: rtl/udp2pcm_pkg.sv
// udp2pcm_pkg: shared FSM encoding, byte order and counter helpers for udp2pcm
package udp2pcm_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  localparam bit LOW_BYTE_FIRST = 1'b1;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction
endpackage

// File: rtl/pcm_fifo_sf.sv
// pcm_fifo_sf: single-clock show-ahead FIFO, registered RAM read doubles as the output register
module pcm_fifo_sf #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [W-1:0]  din_i,
  input  logic          rd_i,
  output logic          valid_o,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   level_o
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  logic [W-1:0] mem [1 << AW];
  logic [AW:0]  wptr_q, rptr_q, level_q;
  logic [W-1:0] dout_q;
  logic         vld_q, pop, fetch;
  assign pop     = vld_q && rd_i;
  assign fetch   = (wptr_q != rptr_q) && (!vld_q || rd_i);
  assign valid_o = vld_q;
  assign dout_o  = dout_q;
  assign level_o = level_q;
  always_ff @(posedge clk) begin
    if (wr_i) mem[wptr_q[AW-1:0]] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      assert (!(wr_i && level_q == DEPTH));
      wptr_q  <= wptr_q + (AW+1)'(wr_i);
      rptr_q  <= rptr_q + (AW+1)'(fetch);
      level_q <= level_q + (AW+1)'(wr_i) - (AW+1)'(pop);
      vld_q   <= fetch ? 1'b1 : (pop ? 1'b0 : vld_q);
      dout_q  <= fetch ? mem[rptr_q[AW-1:0]] : dout_q;
    end
  end
endmodule

// File: rtl/udp2pcm.sv
// udp2pcm: reassembles UDP payload bytes into 16-bit PCM samples, dropping packets that do not fit
module udp2pcm
  import udp2pcm_pkg::*;
#(
  parameter int pcmaw = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcm_udp_rx_en,
  input  logic             pcm_udp_hdr_valid,
  output logic             pcm_udp_hdr_ready,
  input  logic [15:0]      pcm_udp_length,
  input  logic [7:0]       pcm_udp_payload_axis_tdata,
  input  logic             pcm_udp_payload_axis_tvalid,
  output logic             pcm_udp_payload_axis_tready,
  input  logic             pcm_udp_payload_axis_tlast,
  output logic             pcm_out_valid,
  input  logic             pcm_out_ready,
  output logic [15:0]      pcm_out,
  output logic [pcmaw:0]   pcm_level,
  output logic [CNT_W-1:0] pcm_drop_cnt,
  output logic [CNT_W-1:0] pcm_err_cnt
);
  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d, bcnt_q, bcnt_d, word;
  logic [7:0]        low_q, low_d;
  logic [CNT_W-1:0]  drop_q, err_q;
  logic              up_q, hs, beat, last_pos, wr, err_inc, drop_inc, too_big;
  logic [16:0]       free;
  assign pcm_udp_hdr_ready           = up_q && state_q == IDLE;
  assign pcm_udp_payload_axis_tready = state_q != IDLE;
  assign pcm_drop_cnt                = drop_q;
  assign pcm_err_cnt                 = err_q;
  assign hs       = pcm_udp_hdr_valid && pcm_udp_hdr_ready;
  assign beat     = pcm_udp_payload_axis_tvalid && pcm_udp_payload_axis_tready;
  assign last_pos = bcnt_q + 16'd1 == len_q;
  assign free     = 17'(1 << pcmaw) - 17'(pcm_level);
  assign too_big  = {2'b00, pcm_udp_length[15:1]} > free;
  assign word     = LOW_BYTE_FIRST ? {pcm_udp_payload_axis_tdata, low_q} : {low_q, pcm_udp_payload_axis_tdata};
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    low_d    = low_q;
    wr       = 1'b0;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        len_d  = pcm_udp_length;
        bcnt_d = '0;
        if (!pcm_udp_rx_en || pcm_udp_length == '0 || too_big) begin
          state_d  = DROP;
          drop_inc = !pcm_udp_rx_en || pcm_udp_length != '0;
          err_inc  = pcm_udp_rx_en && pcm_udp_length == '0;
        end else state_d = RECV;
      end
      RECV: if (beat) begin
        bcnt_d = bcnt_q + 16'd1;
        low_d  = pcm_udp_payload_axis_tdata;
        wr     = bcnt_q[0];
        if (pcm_udp_payload_axis_tlast) begin
          state_d = IDLE;
          err_inc = !last_pos || len_q[0];
        end else if (last_pos) begin
          state_d = DROP;
          err_inc = 1'b1;
        end
      end
      DROP: state_d = (beat && pcm_udp_payload_axis_tlast) ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      bcnt_q  <= '0;
      low_q   <= '0;
      drop_q  <= '0;
      err_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      low_q   <= low_d;
      drop_q  <= sat_inc(drop_q, drop_inc);
      err_q   <= sat_inc(err_q, err_inc);
      up_q    <= 1'b1;
    end
  end
  pcm_fifo_sf #(.W(16), .AW(pcmaw)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (wr),
    .din_i   (word),
    .rd_i    (pcm_out_ready),
    .valid_o (pcm_out_valid),
    .dout_o  (pcm_out),
    .level_o (pcm_level)
  );
endmodule

// File: tb/tb_udp2pcm.sv
// tb_udp2pcm: table-driven packet vectors plus directed latency, overflow and reset sequences
module tb_udp2pcm;
  logic        clk = 0, rst = 1, rx_en = 1, hdr_valid = 0, tvalid = 0, tlast = 0, pcm_out_ready = 0;
  logic [15:0] length = 0;
  logic [7:0]  tdata = 0;
  logic        hdr_ready, tready, pcm_out_valid;
  logic [15:0] pcm_out, drop_cnt, err_cnt;
  logic [10:0] level;
  int          checks = 0, errors = 0, e_err = 0, e_drop = 0;
  logic [15:0] exp_q[$];
  bit          tog = 0, rdy_set = 1, hold_pend = 0;
  logic [15:0] hold_val;
  typedef struct { int len; int nb; bit rx; int ns; int derr; int ddrop; } vec_t;
  vec_t tv[8];

  udp2pcm #(.pcmaw(10)) dut (
    .clk(clk), .rst(rst), .pcm_udp_rx_en(rx_en),
    .pcm_udp_hdr_valid(hdr_valid), .pcm_udp_hdr_ready(hdr_ready), .pcm_udp_length(length),
    .pcm_udp_payload_axis_tdata(tdata), .pcm_udp_payload_axis_tvalid(tvalid),
    .pcm_udp_payload_axis_tready(tready), .pcm_udp_payload_axis_tlast(tlast),
    .pcm_out_valid(pcm_out_valid), .pcm_out_ready(pcm_out_ready), .pcm_out(pcm_out),
    .pcm_level(level), .pcm_drop_cnt(drop_cnt), .pcm_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) begin
    #1;
    pcm_out_ready = tog ? ~pcm_out_ready : rdy_set;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pend) begin
        chk("hold_valid", pcm_out_valid, 1);
        chk("hold_data", pcm_out, hold_val);
      end
      if (pcm_out_valid && pcm_out_ready) begin
        if (exp_q.size() == 0) fail($sformatf("unexpected_sample got %h", pcm_out));
        else chk("sample", pcm_out, exp_q.pop_front());
      end
    end
    hold_pend = !rst && pcm_out_valid && !pcm_out_ready;
    hold_val  = pcm_out;
  end

  task automatic send(input int len, input int nb, input bit rx, input bit last, input int ns, input logic [7:0] base);
    int t = 0;
    for (int k = 0; k < ns; k++) exp_q.push_back({8'(base + 2*k + 1), 8'(base + 2*k)});
    while (!hdr_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!hdr_ready) begin
      fail("hdr_ready_timeout");
      return;
    end
    rx_en = rx;
    length = 16'(len);
    hdr_valid = 1;
    @(posedge clk); #1;
    hdr_valid = 0;
    chk("tready_after_hdr", tready, 1);
    for (int i = 0; i < nb; i++) begin
      tdata = 8'(base + i);
      tvalid = 1;
      tlast = last && (i == nb - 1);
      @(posedge clk); #1;
    end
    tvalid = 0;
    tlast = 0;
    if (last) chk("hdr_ready_after_tlast", hdr_ready, 1);
  endtask

  task automatic drain();
    int t = 0;
    tog = 0;
    rdy_set = 1;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("level_empty", level, 0);
    chk("valid_empty", pcm_out_valid, 0);
  endtask

  initial begin
    tv[0] = '{128, 128, 1, 64, 0, 0};
    tv[1] = '{5,   5,   1, 2,  1, 0};
    tv[2] = '{8,   3,   1, 1,  1, 0};
    tv[3] = '{4,   7,   1, 2,  1, 0};
    tv[4] = '{16,  16,  0, 0,  0, 1};
    tv[5] = '{0,   4,   1, 0,  1, 0};
    tv[6] = '{2,   2,   1, 1,  0, 0};
    tv[7] = '{3,   3,   1, 1,  1, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_ready", hdr_ready, 0);
    chk("rst_tready", tready, 0);
    chk("rst_valid", pcm_out_valid, 0);
    chk("rst_pcm_out", pcm_out, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err_cnt, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("hdr_ready_after_rst", hdr_ready, 1);

    rdy_set = 0;
    @(posedge clk); #1;
    send(2, 2, 1, 1, 1, 8'hA0);
    chk("lat_w1_valid", pcm_out_valid, 0);
    chk("lat_w1_level", level, 1);
    @(posedge clk); #1;
    chk("lat_w2_valid", pcm_out_valid, 1);
    chk("lat_w2_data", pcm_out, 16'hA1A0);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(tv[i].len, tv[i].nb, tv[i].rx, 1, tv[i].ns, 8'(16 * i));
      drain();
      e_err += tv[i].derr;
      e_drop += tv[i].ddrop;
      chk($sformatf("vec%0d_err", i), err_cnt, e_err);
      chk($sformatf("vec%0d_drop", i), drop_cnt, e_drop);
    end

    tog = 1;
    for (int i = 0; i < 5; i++) send(128, 128, 1, 1, 64, 8'(i * 7));
    drain();
    chk("b2b_err", err_cnt, e_err);
    chk("b2b_drop", drop_cnt, e_drop);

    rdy_set = 0;
    repeat (2) begin @(posedge clk); #1; end
    send(2048, 2048, 1, 1, 1024, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_level_full", level, 1024);
    send(2, 2, 1, 1, 0, 8'h55);
    repeat (3) begin @(posedge clk); #1; end
    e_drop++;
    chk("ovf_level_kept", level, 1024);
    chk("ovf_drop", drop_cnt, e_drop);
    chk("ovf_err", err_cnt, e_err);
    drain();

    rdy_set = 0;
    @(posedge clk); #1;
    send(128, 40, 1, 0, 0, 8'h30);
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", pcm_out_valid, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_hdr_ready", hdr_ready, 0);
    chk("mid_rst_tready", tready, 0);
    exp_q.delete();
    rst = 0;
    rdy_set = 1;
    send(4, 4, 1, 1, 2, 8'hC0);
    drain();
    chk("post_rst_err", err_cnt, 0);
    chk("post_rst_drop", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp2pcm.md
# udp2pcm

Receive-side counterpart of the PCM-to-UDP framer. Accepts UDP header plus byte-wide AXI-stream payload from the UDP stack and reassembles little-endian 16-bit PCM samples into a 2^pcmaw-deep sample FIFO. Presents samples on a valid/ready PCM stream toward the DAC path. Packets that cannot fit in the FIFO are discarded whole, so the DAC never sees a partial packet caused by overflow.

## Interface
- pcmaw, 10: log2 of the FIFO depth in 16-bit samples; max packet = 2^(pcmaw+1) bytes.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- pcm_udp_rx_en  in  1  1 = accept packets into FIFO; 0 = consume and discard every packet.
- pcm_udp_hdr_valid  in  1  header valid.
- pcm_udp_hdr_ready  out  1  header accepted when valid&ready.
- pcm_udp_length  in  16  payload length in bytes, sampled at header handshake.
- pcm_udp_payload_axis_tdata  in  8  payload byte.
- pcm_udp_payload_axis_tvalid  in  1  byte valid.
- pcm_udp_payload_axis_tready  out  1  byte accepted when tvalid&tready.
- pcm_udp_payload_axis_tlast  in  1  last byte of packet.
- pcm_out_valid  out  1  sample valid.
- pcm_out_ready  in  1  downstream accepts sample.
- pcm_out  out  16  PCM sample.
- pcm_level  out  pcmaw+1  samples currently stored, including the output register.
- pcm_drop_cnt  out  16  packets dropped for lack of space or rx_en=0; saturates at 0xFFFF.
- pcm_err_cnt  out  16  malformed packets; saturates at 0xFFFF.

## Operation
- **FSM states:** IDLE, RECV, DROP.
- **IDLE:**
  - hdr_ready=1 and tready=0.
  - On the header handshake, latch len=pcm_udp_length and compute free=2^pcmaw−pcm_level.
  - If rx_en=0, or len=0, or floor(len/2)>free: go to DROP. Increment drop_cnt for rx_en=0 or space; increment err_cnt for len=0.
  - Otherwise go to RECV and set byte counter bcnt=0.
- **RECV:**
  - hdr_ready=0 and tready=1.
  - Even bcnt: hold the byte as the low half.
  - Odd bcnt: write {byte, low} to the FIFO.
  - bcnt increments on every accepted byte.
  - tlast with bcnt+1==len: go to IDLE. If len is odd, discard the final lone byte and increment err_cnt.
  - tlast with bcnt+1<len (truncated): keep words already written, discard the pending low byte, increment err_cnt, go to IDLE.
  - bcnt+1==len without tlast (overlong): go to DROP and increment err_cnt.
- **DROP:**
  - hdr_ready=0 and tready=1; bytes are discarded.
  - tlast returns the FSM to IDLE.
- **Space reservation:** only one packet is in flight, and reads only add space. The check at the header is therefore sufficient, so FIFO overflow is impossible by construction. A write to a full FIFO is a design error and must be asserted in simulation.
- **Output stream:**
  - Standard valid/ready: pcm_out holds steady while valid&!ready.
  - Samples leave in arrival order, with no gaps across packet boundaries.
- **Counters:** saturate at 0xFFFF and never wrap. Only rst clears them.

## Timing
- **Reset values:** FSM=IDLE; all outputs 0, including hdr_ready and tready; FIFO empty; level=0; both counters 0. hdr_ready rises to 1 on the first cycle after rst deasserts.
- **Reset mid-packet:** FIFO contents and the partial packet are flushed. Upstream must restart its packet.
- **Header turnaround:**
  - Header handshake at cycle N gives tready=1 at N+1. The first payload byte may be accepted at N+1.
  - Exit from RECV/DROP on tlast at cycle M gives hdr_ready=1 at M+1.
- **Payload throughput:** one byte per cycle, no back-pressure inside a packet.
- **Write-to-output latency:** sample write at cycle W gives pcm_out_valid at W+2 when the FIFO was empty. FIFO RAM is one registered read plus a show-ahead output register.
- **Sustained output:** one sample per cycle with ready=1 held.
- **pcm_level:** updated the cycle after each write or read. A simultaneous write and read leaves it unchanged.
- **Full FIFO:** a packet with floor(len/2)==free is accepted (exact fit); free+1 samples is dropped.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/RECV/DROP).
  - Byte order constant: low byte first.
  - Counter width (16).
- Natural sub-module: pcm_fifo_sf, a single-clock show-ahead FIFO parameterised by width 16 and depth 2^pcmaw, with a level output. The rest is the FSM, packer and counters in udp2pcm.

## Test plan
- **Nominal packet:** rx_en=1, len=128, bytes 0x00..0x7F, tlast on byte 127 -> 64 samples 0x0100, 0x0302, …, 0x7F7E out in order; err_cnt=0 and drop_cnt=0.
- **Back-to-back with stalls:** 5 packets of len=128 with pcm_out_ready toggling 50% -> 320 samples, no loss, hdr_ready high the cycle after each tlast.
- **Overflow drop:** pcmaw=10, ready=0, send len=2048 then len=2 -> first accepted (level=1024), second dropped, drop_cnt=1, level stays 1024.
- **Malformed packets:**
  - len=5 with tlast on byte 5 -> 2 samples, err_cnt=1.
  - len=8 with tlast on byte 3 -> 1 sample, err_cnt=2.
  - len=4 with tlast on byte 7 -> 2 samples, bytes 5–7 discarded, err_cnt=3.
- **rx_en=0 and len=0:** rx_en=0 packet -> drop_cnt+1, no samples; len=0 packet -> err_cnt+1, consumed to tlast.
- **Reset mid-packet:** assert rst after 40 bytes of a len=128 packet -> level=0, pcm_out_valid=0, counters 0. A fresh packet afterwards is received correctly.
